// File: rtl/mul_pkg.sv
// ---------------------------------------------------------------------------
// mul_pkg
// Shared types and constants for the iterative multiply unit.
//   mul_op_t    : operation encodings carried on MUL_op
//   mul_state_t : sequencer states of mul_unit
//   MUL_R       : multiplier bits retired per iteration (1, or 2 when
//                 MUL_RADIX4_EN is defined)
//   MUL_N       : iteration count for the default 32-bit operand width
//   mulSteps()  : iteration count for an arbitrary operand width
//   takesHigh() : true for the operations that return the upper product half
// Configuration macro: MUL_RADIX4_EN
// ---------------------------------------------------------------------------
package mul_pkg;

   typedef enum logic [1:0] {
      OP_MUL   = 2'b00,
      OP_MULH  = 2'b01,
      OP_MULHU = 2'b10,
      OP_RSVD  = 2'b11
   } mul_op_t;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      BUSY = 2'b01,
      DONE = 2'b10
   } mul_state_t;

`ifdef MUL_RADIX4_EN
   localparam int MUL_R = 2;
`else
   localparam int MUL_R = 1;
`endif

   localparam int MUL_N = 32 / MUL_R;

   function automatic int mulSteps(input int width);
      return width / MUL_R;
   endfunction

   // The reserved encoding behaves like MUL, so only MULH/MULHU pick the
   // upper half of the product.
   function automatic logic takesHigh(input mul_op_t op);
      return (op == OP_MULH) || (op == OP_MULHU);
   endfunction

endpackage

// File: rtl/mul_step.sv
// ---------------------------------------------------------------------------
// mul_step
// One combinational shift-add iteration of the unsigned multiplier.
// The partial product selected by the next MUL_R multiplier bits is added
// into the upper half of the accumulator, and the whole accumulator is then
// shifted right by MUL_R. After W/MUL_R iterations the accumulator holds the
// full 2*W-bit product.
// Ports:
//   acc_i     : current 2*W-bit accumulator
//   mcand_i   : unsigned multiplicand magnitude
//   mcand3_i  : 3x multiplicand, precomputed at issue (radix-4 build only)
//   bits_i    : the MUL_R multiplier bits consumed by this iteration
//   acc_o     : accumulator after this iteration
// Configuration macro: MUL_RADIX4_EN (selects radix-4 partial products)
// ---------------------------------------------------------------------------
module mul_step
   import mul_pkg::*;
#(
   parameter int W = 32
)
(
   input  logic [2*W-1:0]   acc_i,
   input  logic [W-1:0]     mcand_i,
`ifdef MUL_RADIX4_EN
   input  logic [W+1:0]     mcand3_i,
`endif
   input  logic [MUL_R-1:0] bits_i,
   output logic [2*W-1:0]   acc_o
);

   // The upper half never exceeds 2^W-1, so W+MUL_R bits hold the sum of it
   // and the largest partial product without a carry out.
   logic [W+MUL_R-1:0] partial;
   logic [W+MUL_R-1:0] sum;
   logic               unusedLowBits;

   // Partial product selection for this group of multiplier bits.
   always_comb begin
      partial = '0;
`ifdef MUL_RADIX4_EN
      case (bits_i)
         2'd1:    partial = {2'b00, mcand_i};
         2'd2:    partial = {1'b0, mcand_i, 1'b0};
         2'd3:    partial = mcand3_i;
         default: partial = '0;
      endcase
`else
      if (bits_i[0]) begin
         partial = {1'b0, mcand_i};
      end
`endif
   end

   assign sum = {{MUL_R{1'b0}}, acc_i[2*W-1:W]} + partial;

   // Concatenating the sum above the surviving low bits is the right shift;
   // the MUL_R lowest accumulator bits are always zero-filled history and
   // drop off the bottom.
   assign acc_o = {sum, acc_i[W-1:MUL_R]};

   assign unusedLowBits = ^acc_i[MUL_R-1:0];

endmodule

// File: rtl/mul_unit.sv
// ---------------------------------------------------------------------------
// mul_unit
// Iterative integer multiplier for the EX stage. Operands are captured when a
// multiply issues, the pipeline is stalled while the unsigned magnitudes are
// multiplied one step per cycle, and the selected half of the (sign-corrected)
// product is presented in the DONE state.
// Ports:
//   clk           : rising-edge clock
//   reset_n       : asynchronous active-low reset
//   MUL_in_use    : a multiply instruction occupies EX this cycle
//   MUL_op        : 00 MUL, 01 MULH, 10 MULHU, 11 behaves as MUL
//   MUL_operand1  : multiplicand
//   MUL_operand2  : multiplier
//   MUL_stall_in  : downstream stall request, extends DONE
//   MUL_flush     : squash the instruction in EX
//   MUL_result    : selected product half, valid while MUL_done is high
//   MUL_stall     : hold the pipeline
//   MUL_done      : result valid this cycle
// Configuration macro: MUL_RADIX4_EN (two multiplier bits per iteration,
// halving latency; results are identical)
// ---------------------------------------------------------------------------
module mul_unit
   import mul_pkg::*;
#(
   parameter int OPERAND_SIZE = 32
)
(
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    MUL_in_use,
   input  logic [1:0]              MUL_op,
   input  logic [OPERAND_SIZE-1:0] MUL_operand1,
   input  logic [OPERAND_SIZE-1:0] MUL_operand2,
   input  logic                    MUL_stall_in,
   input  logic                    MUL_flush,
   output logic [OPERAND_SIZE-1:0] MUL_result,
   output logic                    MUL_stall,
   output logic                    MUL_done
);

   localparam int W  = OPERAND_SIZE;
   localparam int N  = mulSteps(OPERAND_SIZE);
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   mul_state_t     state_q,  state_d;
   mul_op_t        op_q,     op_d;
   logic [W-1:0]   mcand_q,  mcand_d;
   logic [W-1:0]   mplier_q, mplier_d;
   logic           negate_q, negate_d;
   logic [2*W-1:0] acc_q,    acc_d;
   logic [CW-1:0]  count_q,  count_d;
`ifdef MUL_RADIX4_EN
   logic [W+1:0]   mcand3_q, mcand3_d;
   logic [W+1:0]   issueMcand3;
`endif

   mul_op_t        issueOp;
   logic           issueIsMulh;
   logic [W-1:0]   absOp1;
   logic [W-1:0]   absOp2;
   logic [2*W-1:0] stepAcc;
   logic [2*W-1:0] product;

   // Only MULH treats operands as signed. Negating the most-negative value
   // in W bits yields 2^(W-1), which is exactly its magnitude when read as
   // unsigned, so no extra bit is needed.
   assign issueOp     = mul_op_t'(MUL_op);
   assign issueIsMulh = (issueOp == OP_MULH);
   assign absOp1      = (issueIsMulh && MUL_operand1[W-1]) ? -MUL_operand1 : MUL_operand1;
   assign absOp2      = (issueIsMulh && MUL_operand2[W-1]) ? -MUL_operand2 : MUL_operand2;
`ifdef MUL_RADIX4_EN
   assign issueMcand3 = {2'b00, absOp1} + {1'b0, absOp1, 1'b0};
`endif

   mul_step #(
      .W        (W)
   ) u_step (
      .acc_i    (acc_q),
      .mcand_i  (mcand_q),
`ifdef MUL_RADIX4_EN
      .mcand3_i (mcand3_q),
`endif
      .bits_i   (mplier_q[MUL_R-1:0]),
      .acc_o    (stepAcc)
   );

   // State and datapath registers; reset clears everything so nothing from
   // an interrupted multiply survives.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         op_q     <= OP_MUL;
         mcand_q  <= '0;
         mplier_q <= '0;
         negate_q <= 1'b0;
         acc_q    <= '0;
         count_q  <= '0;
`ifdef MUL_RADIX4_EN
         mcand3_q <= '0;
`endif
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         negate_q <= negate_d;
         acc_q    <= acc_d;
         count_q  <= count_d;
`ifdef MUL_RADIX4_EN
         mcand3_q <= mcand3_d;
`endif
      end
   end

   // Next-state logic. Flush wins over both issue and completion; stall_in
   // only matters in DONE, where it holds the result for the pipeline.
   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      negate_d = negate_q;
      acc_d    = acc_q;
      count_d  = count_q;
`ifdef MUL_RADIX4_EN
      mcand3_d = mcand3_q;
`endif
      case (state_q)
         IDLE: begin
            if (MUL_in_use && !MUL_flush) begin
               state_d  = BUSY;
               op_d     = issueOp;
               mcand_d  = absOp1;
               mplier_d = absOp2;
               negate_d = issueIsMulh && (MUL_operand1[W-1] ^ MUL_operand2[W-1]);
               acc_d    = '0;
               count_d  = '0;
`ifdef MUL_RADIX4_EN
               mcand3_d = issueMcand3;
`endif
            end
         end
         BUSY: begin
            if (MUL_flush) begin
               state_d = IDLE;
            end else begin
               acc_d    = stepAcc;
               mplier_d = mplier_q >> MUL_R;
               count_d  = count_q + CW'(1);
               if (count_q == CW'(N - 1)) begin
                  state_d = DONE;
               end
            end
         end
         DONE: begin
            if (MUL_flush || !MUL_stall_in) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Sign correction is applied to the full-width product before the half
   // is selected, so MULH gets the correct borrow into the upper half.
   assign product = negate_q ? -acc_q : acc_q;

   assign MUL_done   = (state_q == DONE);
   assign MUL_result = (state_q != DONE) ? '0 :
                       takesHigh(op_q)   ? product[2*W-1:W] : product[W-1:0];

   // Combinational so the issue cycle itself stalls. Gating with reset_n
   // keeps every output low for the whole time reset is asserted, even
   // while the pipeline still presents a multiply.
   assign MUL_stall = reset_n && MUL_in_use &&
                      ((state_q == IDLE) || (state_q == BUSY) || MUL_stall_in);

endmodule

// File: tb/tb_mul_unit.sv
// ---------------------------------------------------------------------------
// tb_mul_unit
// Self-checking bench for mul_unit: directed cases (basic MUL, MULH sign,
// MULHU, extremes, DONE hold, flush, reset mid-operation) followed by
// randomized operations checked against a 64-bit arithmetic reference.
// Latency expectations follow MUL_RADIX4_EN when it is defined.
// ---------------------------------------------------------------------------
module tb_mul_unit;

   localparam int W = 32;
`ifdef MUL_RADIX4_EN
   localparam int N_STEPS = 16;
`else
   localparam int N_STEPS = 32;
`endif

   logic          clk = 1'b0;
   logic          reset_n;
   logic          MUL_in_use;
   logic [1:0]    MUL_op;
   logic [W-1:0]  MUL_operand1;
   logic [W-1:0]  MUL_operand2;
   logic          MUL_stall_in;
   logic          MUL_flush;
   logic [W-1:0]  MUL_result;
   logic          MUL_stall;
   logic          MUL_done;

   int testCount = 0;
   int failCount = 0;

   mul_unit #(
      .OPERAND_SIZE (W)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .MUL_in_use   (MUL_in_use),
      .MUL_op       (MUL_op),
      .MUL_operand1 (MUL_operand1),
      .MUL_operand2 (MUL_operand2),
      .MUL_stall_in (MUL_stall_in),
      .MUL_flush    (MUL_flush),
      .MUL_result   (MUL_result),
      .MUL_stall    (MUL_stall),
      .MUL_done     (MUL_done)
   );

   // Free-running clock, 10 time units per cycle.
   always #5 clk = ~clk;

   // Backstop against a hung run; every wait below is already bounded.
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation did not finish, observed timeout required finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Reference: plain 64-bit arithmetic on the architectural operand values.
   function automatic logic [31:0] refModel(input logic [1:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
      logic signed [63:0] sa;
      logic signed [63:0] sb;
      logic signed [63:0] sp;
      logic        [63:0] up;
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      sp = sa * sb;
      up = {32'd0, a} * {32'd0, b};
      case (op)
         2'b01:   return sp[63:32];
         2'b10:   return up[63:32];
         default: return up[31:0];
      endcase
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      testCount++;
      assert (obs === exp) else begin
         failCount++;
         $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Issue one multiply, count the stall cycles up to DONE, check the
   // result, optionally hold DONE with stall_in for 'hold' cycles.
   // Operands and op are scrambled after issue to prove they were latched;
   // 'noise' pulses stall_in during BUSY, which must not disturb anything.
   task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] expRes, input int hold, input bit noise);
      int stallCycles;
      @(negedge clk);
      MUL_in_use   = 1'b1;
      MUL_op       = op;
      MUL_operand1 = a;
      MUL_operand2 = b;
      MUL_flush    = 1'b0;
      MUL_stall_in = 1'b0;
      #1;
      checkOutput("issue_done", 32'(MUL_done), 32'd0);
      stallCycles = 0;
      while (MUL_stall === 1'b1 && MUL_done !== 1'b1 && stallCycles < 200) begin
         stallCycles++;
         @(negedge clk);
         if (stallCycles == 1) begin
            MUL_operand1 = $urandom;
            MUL_operand2 = $urandom;
            MUL_op       = 2'($urandom_range(0, 3));
         end
         MUL_stall_in = noise && (stallCycles >= 3) && (stallCycles < 8);
         #1;
      end
      checkOutput("stall_cycles", 32'(stallCycles), 32'(N_STEPS + 1));
      checkOutput("done", 32'(MUL_done), 32'd1);
      checkOutput("done_stall", 32'(MUL_stall), 32'd0);
      checkOutput("result", MUL_result, expRes);
      for (int i = 0; i < hold; i++) begin
         MUL_stall_in = 1'b1;
         #1;
         checkOutput("hold_stall", 32'(MUL_stall), 32'd1);
         checkOutput("hold_done", 32'(MUL_done), 32'd1);
         checkOutput("hold_result", MUL_result, expRes);
         @(negedge clk);
         #1;
      end
      if (hold > 0) begin
         MUL_stall_in = 1'b0;
         #1;
         checkOutput("release_done", 32'(MUL_done), 32'd1);
         checkOutput("release_stall", 32'(MUL_stall), 32'd0);
         checkOutput("release_result", MUL_result, expRes);
      end
   endtask

   initial begin
      logic [31:0] edgeVals [5];
      logic [1:0]  rOp;
      logic [31:0] rA;
      logic [31:0] rB;

      edgeVals[0] = 32'h0000_0000;
      edgeVals[1] = 32'h0000_0001;
      edgeVals[2] = 32'h8000_0000;
      edgeVals[3] = 32'hFFFF_FFFF;
      edgeVals[4] = 32'h7FFF_FFFF;

      // Reset state, with a multiply presented so the stall gating is seen.
      reset_n      = 1'b0;
      MUL_in_use   = 1'b1;
      MUL_op       = 2'b00;
      MUL_operand1 = 32'd0;
      MUL_operand2 = 32'd0;
      MUL_stall_in = 1'b0;
      MUL_flush    = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      checkOutput("reset_stall", 32'(MUL_stall), 32'd0);
      checkOutput("reset_done", 32'(MUL_done), 32'd0);
      checkOutput("reset_result", MUL_result, 32'd0);
      MUL_in_use = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;

      // Basic MUL, then an explicit idle cycle.
      applyStimulus(2'b00, 32'd7, 32'd6, 32'd42, 0, 1'b0);
      @(negedge clk);
      MUL_in_use = 1'b0;
      #1;
      checkOutput("idle_done", 32'(MUL_done), 32'd0);
      checkOutput("idle_result", MUL_result, 32'd0);

      // Sign handling and high halves, issued back-to-back.
      applyStimulus(2'b01, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 0, 1'b1);
      applyStimulus(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0, 1'b0);
      applyStimulus(2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 3, 1'b0);
      applyStimulus(2'b11, 32'h1234_5678, 32'h0000_0010, 32'h2345_6780, 0, 1'b0);
      applyStimulus(2'b00, 32'hFFFF_FFFF, 32'h0000_0003, 32'hFFFF_FFFD, 0, 1'b0);

      // Flush in DONE beats a pending stall_in.
      applyStimulus(2'b00, 32'd11, 32'd13, 32'd143, 0, 1'b0);
      MUL_stall_in = 1'b1;
      MUL_flush    = 1'b1;
      #1;
      checkOutput("dflush_same_cycle_done", 32'(MUL_done), 32'd1);
      @(negedge clk);
      MUL_flush    = 1'b0;
      MUL_stall_in = 1'b0;
      MUL_in_use   = 1'b0;
      #1;
      checkOutput("dflush_done", 32'(MUL_done), 32'd0);
      checkOutput("dflush_result", MUL_result, 32'd0);

      // Flush at issue: nothing starts, so the next issue has full latency.
      @(negedge clk);
      MUL_in_use   = 1'b1;
      MUL_flush    = 1'b1;
      MUL_op       = 2'b00;
      MUL_operand1 = 32'd9;
      MUL_operand2 = 32'd9;
      @(negedge clk);
      MUL_flush  = 1'b0;
      MUL_in_use = 1'b0;
      #1;
      checkOutput("iflush_done", 32'(MUL_done), 32'd0);

      // Flush mid-BUSY at count=10.
      @(negedge clk);
      MUL_in_use   = 1'b1;
      MUL_op       = 2'b00;
      MUL_operand1 = 32'd100;
      MUL_operand2 = 32'd200;
      repeat (11) @(negedge clk);
      MUL_flush = 1'b1;
      #1;
      checkOutput("bflush_busy_stall", 32'(MUL_stall), 32'd1);
      @(negedge clk);
      MUL_flush  = 1'b0;
      MUL_in_use = 1'b0;
      #1;
      checkOutput("bflush_done", 32'(MUL_done), 32'd0);
      checkOutput("bflush_stall", 32'(MUL_stall), 32'd0);
      applyStimulus(2'b00, 32'd123, 32'd456, 32'd56088, 0, 1'b0);

      // Reset asserted mid-BUSY.
      @(negedge clk);
      MUL_in_use   = 1'b1;
      MUL_op       = 2'b10;
      MUL_operand1 = 32'hFFFF_0000;
      MUL_operand2 = 32'hFFFF_0000;
      repeat (5) @(negedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      checkOutput("rst_busy_stall", 32'(MUL_stall), 32'd0);
      checkOutput("rst_busy_done", 32'(MUL_done), 32'd0);
      checkOutput("rst_busy_result", MUL_result, 32'd0);
      @(negedge clk);
      MUL_in_use = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      applyStimulus(2'b00, 32'd3, 32'd5, 32'd15, 0, 1'b0);

      // Randomized operations, mixing edge operands with random ones.
      for (int t = 0; t < 30; t++) begin
         rOp = 2'($urandom_range(0, 3));
         rA  = ($urandom_range(0, 3) == 0) ? edgeVals[$urandom_range(0, 4)] : $urandom;
         rB  = ($urandom_range(0, 3) == 0) ? edgeVals[$urandom_range(0, 4)] : $urandom;
         applyStimulus(rOp, rA, rB, refModel(rOp, rA, rB),
                       int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
      end

      @(negedge clk);
      MUL_in_use = 1'b0;
      repeat (2) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
